// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the mem_copy_dma block-copy engine:
// default widths and the FSM state encoding.
package mem_copy_dma_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 16;

  // One word per three cycles in copy mode: READ presents the source
  // address, LATCH captures the returned word, WRITE stores it.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: block-copy initiator on a single-port memory.
// Copies `length` words from srcAddr to dstAddr in ascending order.
// Optional fill mode (macro MEM_COPY_DMA_FILL_EN) writes a constant
// instead of copying, skipping the read phase.
//
// Handshake: start is a request pulse that is only accepted while the
// FSM is in IDLE; once accepted, busy stays high until the last word is
// written, then done pulses for exactly one cycle. Requests arriving
// while busy or done are high are dropped, not queued.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddr,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic [ADDR_WIDTH-1:0] length,
`ifdef MEM_COPY_DMA_FILL_EN
  input  logic                  fillMode,
  input  logic [DATA_WIDTH-1:0] fillValue,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memDataIn
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  fill_q, fill_d;
  logic                  req_fill;
  logic [DATA_WIDTH-1:0] req_fill_value;

  // Fill request as seen at the port; constant zero when fill is compiled out.
`ifdef MEM_COPY_DMA_FILL_EN
  assign req_fill       = fillMode;
  assign req_fill_value = fillValue;
`else
  assign req_fill       = 1'b0;
  assign req_fill_value = '0;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state logic; a zero-length request goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0)  state_d = ST_DONE;
          else if (req_fill) state_d = ST_WRITE;
          else               state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: state_d = ST_WRITE;
      ST_WRITE: begin
        if (count_q == ADDR_WIDTH'(1)) state_d = ST_DONE;
        else if (fill_q)               state_d = ST_WRITE;
        else                           state_d = ST_READ;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: latch request, capture read data, step pointers per write.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = srcAddr;
          dst_d   = dstAddr;
          count_d = length;
          fill_d  = req_fill;
          if (req_fill) buf_d = req_fill_value;
        end
      end
      ST_LATCH: buf_d = memDataIn;
      ST_WRITE: begin
        // Pointer arithmetic wraps modulo 2^ADDR_WIDTH by construction.
        src_d   = src_q + ADDR_WIDTH'(1);
        dst_d   = dst_q + ADDR_WIDTH'(1);
        count_d = count_q - ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registers only; memDataIn never reaches a port.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    memAddress     = '0;
    memDataOut     = '0;
    memWriteEnable = 1'b0;
    case (state_q)
      ST_READ, ST_LATCH: begin
        busy       = 1'b1;
        memAddress = src_q;
      end
      ST_WRITE: begin
        busy           = 1'b1;
        memAddress     = dst_q;
        memDataOut     = buf_q;
        memWriteEnable = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural single-port memory
// (registered read, one-cycle latency) as the responder.
// Build with +define+MEM_COPY_DMA_FILL_EN to include the fill scenario.
module tb_mem_copy_dma;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
`ifdef MEM_COPY_DMA_FILL_EN
  logic        fill_mode = 1'b0;
  logic [15:0] fill_value = '0;
`endif
  logic        busy, done, mem_we;
  logic [15:0] mem_addr, mem_dout, mem_rd;

  mem_copy_dma dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .srcAddr        (src_addr),
    .dstAddr        (dst_addr),
    .length         (len),
`ifdef MEM_COPY_DMA_FILL_EN
    .fillMode       (fill_mode),
    .fillValue      (fill_value),
`endif
    .busy           (busy),
    .done           (done),
    .memAddress     (mem_addr),
    .memDataOut     (mem_dout),
    .memWriteEnable (mem_we),
    .memDataIn      (mem_rd)
  );

  // ---------------- memory responder ----------------
  logic [15:0] mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_dout;
    mem_rd <= mem[mem_addr];
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int done_first, done_last, done_cnt, busy_err, we_cnt;
  logic [15:0] addr_log [0:63];
  logic        we_log   [0:63];
  logic [15:0] dout_log [0:63];

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Start is high in cycle 0; edge 0 accepts it; cycle c is sampled #1 after edge c-1.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int hold, input int restart_c, input int reset_c,
                          input int busy_last, input int ncyc);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    done_first = -1; done_last = -1; done_cnt = 0; busy_err = 0; we_cnt = 0;
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == restart_c) begin
        start = 1'b1; src_addr = s + 16'h0100; dst_addr = d + 16'h0100; len = l + 16'd1;
      end
      if (c == reset_c) reset = 1'b1;
      if (done) begin
        if (done_first < 0) done_first = c;
        done_last = c;
        done_cnt++;
      end
      if (busy !== (c <= busy_last)) busy_err++;
      if (mem_we) we_cnt++;
      if (c < 64) begin
        addr_log[c] = mem_addr; we_log[c] = mem_we; dout_log[c] = mem_dout;
      end
      @(posedge clk); #1;
      if (hold == 0) start = 1'b0;
      reset = 1'b0;
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (mem_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", mem_dout); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", mem_we); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %0b done %0b want 0 0", busy, done); end
  endtask

  task automatic test_basic_copy();
    poke(16'h0000, 16'd100); poke(16'h0001, 16'd200); poke(16'h0002, 16'd300);
    run_copy(16'h0000, 16'h0010, 16'd3, 0, 0, 0, 9, 12);
    n_cmp++; if (done_first !== 10) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 10", done_first); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_err !== 0) begin n_fail++; $display("FAIL basic_busy_window: got %0d bad cycles want 0", busy_err); end
    n_cmp++; if (we_cnt !== 3) begin n_fail++; $display("FAIL basic_write_count: got %0d want 3", we_cnt); end
    n_cmp++; if (addr_log[1] !== 16'h0000 || we_log[1] !== 1'b0) begin n_fail++; $display("FAIL basic_read_addr: got %0h/%0b want 0/0", addr_log[1], we_log[1]); end
    n_cmp++; if (addr_log[3] !== 16'h0010 || we_log[3] !== 1'b1 || dout_log[3] !== 16'd100) begin n_fail++; $display("FAIL basic_first_write: got %0h/%0b/%0d want 10/1/100", addr_log[3], we_log[3], dout_log[3]); end
    n_cmp++; if (addr_log[4] !== 16'h0001) begin n_fail++; $display("FAIL basic_second_read: got %0h want 1", addr_log[4]); end
    n_cmp++; if (addr_log[10] !== 16'h0000 || we_log[10] !== 1'b0) begin n_fail++; $display("FAIL basic_done_outputs: got %0h/%0b want 0/0", addr_log[10], we_log[10]); end
    n_cmp++; if (mem[16'h0010] !== 16'd100) begin n_fail++; $display("FAIL basic_mem10: got %0d want 100", mem[16'h0010]); end
    n_cmp++; if (mem[16'h0011] !== 16'd200) begin n_fail++; $display("FAIL basic_mem11: got %0d want 200", mem[16'h0011]); end
    n_cmp++; if (mem[16'h0012] !== 16'd300) begin n_fail++; $display("FAIL basic_mem12: got %0d want 300", mem[16'h0012]); end
  endtask

  task automatic test_zero_length();
    poke(16'h0004, 16'h4444); poke(16'h0008, 16'h8888);
    run_copy(16'h0004, 16'h0008, 16'd0, 0, 0, 0, 0, 4);
    n_cmp++; if (done_first !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", done_first); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (we_cnt !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", we_cnt); end
    n_cmp++; if (busy_err !== 0) begin n_fail++; $display("FAIL zero_busy: got %0d bad cycles want 0", busy_err); end
    n_cmp++; if (mem[16'h0008] !== 16'h8888) begin n_fail++; $display("FAIL zero_mem8: got %0h want 8888", mem[16'h0008]); end
  endtask

  task automatic test_wrap();
    poke(16'hFFFF, 16'd7); poke(16'h0000, 16'd9);
    poke(16'h0100, 16'h0000); poke(16'h0101, 16'h0000);
    run_copy(16'hFFFF, 16'h0100, 16'd2, 0, 0, 0, 6, 8);
    n_cmp++; if (done_first !== 7) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 7", done_first); end
    n_cmp++; if (addr_log[4] !== 16'h0000) begin n_fail++; $display("FAIL wrap_read_addr: got %0h want 0", addr_log[4]); end
    n_cmp++; if (mem[16'h0100] !== 16'd7) begin n_fail++; $display("FAIL wrap_mem100: got %0d want 7", mem[16'h0100]); end
    n_cmp++; if (mem[16'h0101] !== 16'd9) begin n_fail++; $display("FAIL wrap_mem101: got %0d want 9", mem[16'h0101]); end
  endtask

  task automatic test_reset_mid_copy();
    poke(16'h0000, 16'd11); poke(16'h0001, 16'd22); poke(16'h0002, 16'd33); poke(16'h0003, 16'd44);
    poke(16'h0030, 16'hAAAA); poke(16'h0031, 16'hAAAA); poke(16'h0040, 16'hAAAA);
    run_copy(16'h0000, 16'h0030, 16'd4, 0, 0, 5, 5, 9);
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt); end
    n_cmp++; if (busy_err !== 0) begin n_fail++; $display("FAIL rst_busy_drop: got %0d bad cycles want 0", busy_err); end
    n_cmp++; if (we_cnt !== 1) begin n_fail++; $display("FAIL rst_write_count: got %0d want 1", we_cnt); end
    n_cmp++; if (mem[16'h0030] !== 16'd11) begin n_fail++; $display("FAIL rst_mem30: got %0d want 11", mem[16'h0030]); end
    n_cmp++; if (mem[16'h0031] !== 16'hAAAA) begin n_fail++; $display("FAIL rst_mem31: got %0h want aaaa", mem[16'h0031]); end
    run_copy(16'h0001, 16'h0040, 16'd1, 0, 0, 0, 3, 5);
    n_cmp++; if (done_first !== 4) begin n_fail++; $display("FAIL rst_restart_done: got %0d want 4", done_first); end
    n_cmp++; if (mem[16'h0040] !== 16'd22) begin n_fail++; $display("FAIL rst_restart_mem40: got %0d want 22", mem[16'h0040]); end
  endtask

  task automatic test_start_while_busy();
    poke(16'h0050, 16'h1234); poke(16'h0051, 16'h5678);
    poke(16'h0160, 16'hAAAA); poke(16'h0060, 16'h0000); poke(16'h0061, 16'h0000);
    run_copy(16'h0050, 16'h0060, 16'd2, 0, 2, 0, 6, 10);
    n_cmp++; if (done_first !== 7) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d want 7", done_first); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_err !== 0) begin n_fail++; $display("FAIL busy_start_busy: got %0d bad cycles want 0", busy_err); end
    n_cmp++; if (mem[16'h0060] !== 16'h1234 || mem[16'h0061] !== 16'h5678) begin n_fail++; $display("FAIL busy_start_data: got %0h %0h want 1234 5678", mem[16'h0060], mem[16'h0061]); end
    n_cmp++; if (mem[16'h0160] !== 16'hAAAA) begin n_fail++; $display("FAIL busy_start_ignored: got %0h want aaaa", mem[16'h0160]); end
  endtask

  task automatic test_back_to_back();
    poke(16'h0070, 16'h0000);
    run_copy(16'h0050, 16'h0070, 16'd1, 1, 0, 0, 100, 10);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (done_first !== 4) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 4", done_first); end
    n_cmp++; if (done_last !== 9) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 9", done_last); end
    n_cmp++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_cmp++; if (mem[16'h0070] !== 16'h1234) begin n_fail++; $display("FAIL b2b_mem70: got %0h want 1234", mem[16'h0070]); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_settled: got busy %0b want 0", busy); end
  endtask

`ifdef MEM_COPY_DMA_FILL_EN
  task automatic test_fill();
    for (int i = 0; i < 4; i++) poke(16'h0020 + 16'(i), 16'h0000);
    fill_mode = 1'b1; fill_value = 16'hBEEF;
    run_copy(16'h0000, 16'h0020, 16'd4, 0, 0, 0, 4, 7);
    fill_mode = 1'b0;
    n_cmp++; if (done_first !== 5) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want 5", done_first); end
    n_cmp++; if (we_cnt !== 4) begin n_fail++; $display("FAIL fill_write_count: got %0d want 4", we_cnt); end
    n_cmp++; if (addr_log[1] !== 16'h0020 || we_log[1] !== 1'b1) begin n_fail++; $display("FAIL fill_no_read: got %0h/%0b want 20/1", addr_log[1], we_log[1]); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0020 + 16'(i)] !== 16'hBEEF) begin n_fail++; $display("FAIL fill_mem%0d: got %0h want beef", i, mem[16'h0020 + 16'(i)]); end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_reset_mid_copy();
    test_start_while_busy();
    test_back_to_back();
`ifdef MEM_COPY_DMA_FILL_EN
    test_fill();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
